// File: rtl/hazard_unit_if.sv
// Data-memory request handshake between the hazard unit and the data memory.
interface hazard_unit_if;
    logic dmem_req;
    logic dmem_ready;

    modport master (output dmem_req, input dmem_ready);
    modport slave  (input dmem_req, output dmem_ready);
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard and stall controller for the 5-stage MIPS core.
// Forwarding, stall and flush outputs are combinational; the memory-wait
// FSM and the stall-event counters are the only state.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no outstanding memory access, pipeline free to advance
//   MEM_WAIT | data memory busy on an access, pipeline frozen until ready
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             memwriteM,
    input  logic             branchD,
    input  logic             orpcsrcD,
    hazard_unit_if.master    dmem,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [CNT_W-1:0] lwstall_cnt,
    output logic [CNT_W-1:0] brstall_cnt,
    output logic [CNT_W-1:0] memstall_cnt
);

    typedef enum logic {IDLE, MEM_WAIT} state_t;

    state_t state, nextState;
    logic   lwStall, brStall, memOp, memStall, lwEvent, brEvent;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

    // Operand forwarding: Memory stage result takes priority over Writeback.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (regwriteM && regMatch(writeregM, rsE))      forwardAE = 2'b10;
        else if (regwriteW && regMatch(writeregW, rsE)) forwardAE = 2'b01;
        if (regwriteM && regMatch(writeregM, rtE))      forwardBE = 2'b10;
        else if (regwriteW && regMatch(writeregW, rtE)) forwardBE = 2'b01;
        forwardAD = regwriteM && regMatch(writeregM, rsD);
        forwardBD = regwriteM && regMatch(writeregM, rtD);
    end

    // Hazard detection terms feeding the stall/flush priority logic.
    always_comb begin
        lwStall = memtoregE && (regMatch(rtE, rsD) || regMatch(rtE, rtD));
        brStall = branchD &&
                  ((regwriteE && (regMatch(writeregE, rsD) || regMatch(writeregE, rtD))) ||
                   (memtoregM && (regMatch(writeregM, rsD) || regMatch(writeregM, rtD))));
        memOp   = memtoregM || memwriteM;
    end

    // Memory-wait state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next state, memory handshake and stall/flush outputs; a frozen
    // pipeline masks the load-use and branch stalls.
    always_comb begin
        nextState = state;
        dmem.dmem_req = 1'b0;
        memStall  = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        lwEvent   = 1'b0;
        brEvent   = 1'b0;
        case (state)
            IDLE: begin
                dmem.dmem_req = memOp;
                memStall = memOp && !dmem.dmem_ready;
                if (memStall) nextState = MEM_WAIT;
            end
            MEM_WAIT: begin
                dmem.dmem_req = 1'b1;
                memStall = !dmem.dmem_ready;
                if (dmem.dmem_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (memStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            lwEvent = lwStall;
            brEvent = brStall;
            stallF  = lwStall || brStall;
            stallD  = lwStall || brStall;
            flushE  = lwStall || brStall;
            flushD  = orpcsrcD && !(lwStall || brStall);
        end
    end

    // Saturating stall-event counters for performance debug.
    always_ff @(posedge clk) begin
        if (reset) begin
            lwstall_cnt  <= '0;
            brstall_cnt  <= '0;
            memstall_cnt <= '0;
        end else begin
            if (lwEvent && (lwstall_cnt != '1))   lwstall_cnt  <= lwstall_cnt + CNT_W'(1);
            if (brEvent && (brstall_cnt != '1))   brstall_cnt  <= brstall_cnt + CNT_W'(1);
            if (memStall && (memstall_cnt != '1)) memstall_cnt <= memstall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the 5-stage pipelined MIPS core. It consumes the control signals and register specifiers that the controller and datapath carry down the pipeline (regwrite/memtoreg per stage, branch/jump resolution in Decode). From them it produces forwarding selects, per-stage stall and flush enables, and the data-memory request handshake. It owns one sequential element: a memory-wait state machine that freezes the pipeline while a variable-latency data memory is busy. It also keeps saturating stall-event counters for performance debug.

## Interface
- CNT_W, 16, width of each stall-event counter

- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high
- rsD, rtD  input  5 each  source registers of instruction in Decode
- rsE, rtE  input  5 each  source registers in Execute
- writeregE, writeregM, writeregW  input  5 each  destination register per stage
- regwriteE, regwriteM, regwriteW  input  1 each  stage writes the register file
- memtoregE, memtoregM  input  1 each  stage holds a load
- memwriteM  input  1  Memory stage holds a store
- branchD  input  1  Decode holds a branch
- orpcsrcD  input  1  branch taken or jump in Decode (pcsrcD != 0)
- dmem_ready  input  1  data memory completes the current access this cycle
- forwardAD, forwardBD  output  1 each  Decode comparator operand from ALUOutM
- forwardAE, forwardBE  output  2 each  00 register file, 01 ResultW, 10 ALUOutM
- stallF, stallD, stallE, stallM  output  1 each  hold the PC / pipeline register
- flushD, flushE, flushW  output  1 each  insert a bubble into the register
- dmem_req  output  1  data memory access request
- lwstall_cnt, brstall_cnt, memstall_cnt  output  CNT_W each  saturating event counters

## Operation
- Register 0 never matches: every comparison below also requires the specifier to be nonzero.
- Forwarding is combinational:
  - forwardAE = 10 if regwriteM & writeregM==rsE; else 01 if regwriteW & writeregW==rsE; else 00.
  - forwardBE is the same using rtE.
  - forwardAD = regwriteM & writeregM==rsD; forwardBD uses rtD.
- lwstall = memtoregE & (rtE==rsD | rtE==rtD).
- brstall = branchD & ((regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD))).
- memop = memtoregM | memwriteM.
- FSM states: IDLE, MEM_WAIT.
  - IDLE → MEM_WAIT when memop & ~dmem_ready.
  - MEM_WAIT → IDLE when dmem_ready.
  - Otherwise the state holds.
- dmem_req = (IDLE & memop) | MEM_WAIT. Combinational from the state register and memop.
- memstall = (IDLE & memop & ~dmem_ready) | (MEM_WAIT & ~dmem_ready).
- Output priority, memstall dominating:
  - When memstall is active: stallF = stallD = stallE = stallM = 1, flushW = 1, flushE = 0, flushD = 0. lwstall and brstall are masked.
  - Otherwise: stallF = stallD = lwstall | brstall; flushE = lwstall | brstall; flushD = orpcsrcD & ~(lwstall | brstall); stallE = stallM = flushW = 0.
- Counters:
  - Each counter increments by 1 in every cycle its event is active: lwstall_cnt on unmasked lwstall, brstall_cnt on unmasked brstall, memstall_cnt on memstall.
  - Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- All stall, flush, forward and dmem_req outputs are combinational, valid in the same cycle as their inputs.
- The FSM state and the counters are registered and update on the rising edge of clk.
- Reset, on the clock edge:
  - state goes to IDLE and all counters go to 0.
  - With all inputs low, every output reads 0.
- Reset asserted in MEM_WAIT: state is IDLE on the next cycle. dmem_req drops unless memop is still high.
- Zero-wait memory (dmem_ready=1 in the same cycle as memop, in IDLE): no stall, no state change, memstall_cnt unchanged.
- A memory access with N wait cycles produces exactly N cycles of memstall:
  - the IDLE cycle with ~dmem_ready, plus
  - N−1 MEM_WAIT cycles.
  - The pipeline releases in the cycle where dmem_ready=1.
- lwstall and orpcsrcD in the same cycle: the stall wins and flushD = 0, because the branch re-resolves after the bubble.

## Test plan
- Forwarding priority:
  - regwriteM=1, writeregM=5; regwriteW=1, writeregW=5; rsE=5 → forwardAE=10.
  - Drop regwriteM → forwardAE=01.
  - Set rsE=0 with writeregM=0 → forwardAE=00.
- Load-use: memtoregE=1, rtE=8, rsD=8 → stallF=stallD=flushE=1 for one cycle; lwstall_cnt increments 0→1.
- Branch hazard and taken branch:
  - branchD=1, regwriteE=1, writeregE=3, rtD=3 → stallD=1, flushE=1, flushD=0 even with orpcsrcD=1.
  - Clear the hazard with orpcsrcD=1 → flushD=1.
- Memory wait:
  - memtoregM=1 with dmem_ready low for 3 cycles, then high → dmem_req high for 4 cycles and stallF/D/E/M=1, flushW=1 for 3 cycles.
  - Result: memstall_cnt=3, state back to IDLE.
  - Overlap lwstall during the wait → flushE stays 0 and lwstall_cnt is unchanged.
- Reset mid-operation: assert reset in MEM_WAIT with memop=0 → next cycle state IDLE, dmem_req=0, all counters 0.
- Saturation: CNT_W=4, hold lwstall for 20 cycles → lwstall_cnt stops at 15.
